dual_port_ram: RTL and testbench
================================

Name: dual_port_ram

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, shared clock.
- Storage primitive used by control blocks, e.g. the loop controller's max-iteration table and current-iteration table.
- Depth is 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Read data is registered; write is synchronous.

Parameters:
- ADDR_WIDTH, default 8: address width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, default 16: word width in bits.
- OUTPUT_REG, default 0: 0 = read latency 1 cycle; 1 = extra output pipeline register, read latency 2 cycles.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_write_addr  input  ADDR_WIDTH  write address.
- s_write_req  input  1  write enable.
- s_write_data  input  DATA_WIDTH  write data.
- s_read_addr  input  ADDR_WIDTH  read address.
- s_read_req  input  1  read enable.
- s_read_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Storage array mem[0 .. 2^ADDR_WIDTH-1]; contents NOT cleared by reset and undefined until written.
- Write: at rising edge with s_write_req=1, mem[s_write_addr] <= s_write_data. With s_write_req=0, no change.
- Read, OUTPUT_REG=0:
  - At rising edge with s_read_req=1, read register <= mem[s_read_addr].
  - Data is visible on s_read_data in the next cycle (latency 1).
  - With s_read_req=0, the register holds its previous value.
- Read, OUTPUT_REG=1:
  - Second register stage loads from the first stage every cycle.
  - Latency 2; the hold behaviour of the first stage is unchanged.
- Reset: while reset=1 at a rising edge, all read-data register stages clear to 0, so s_read_data=0 after reset. Reset has priority over s_read_req.
- Writes are still accepted during reset; mem is not gated by reset.
- Read-during-write to the same address in the same cycle is read-first: the read returns the old contents, and the new value is visible on the next read.
- Different-address simultaneous read and write are fully independent.
- Address range covers the full array; no out-of-range case and no wrap logic.
- No handshake back-pressure; a request is always accepted in its cycle.
- Reset mid-operation: any pending read result is discarded (output forced to 0); subsequent reads behave normally.
- No combinational path from any input to s_read_data.

Decomposition:
- No shared package needed; only the parameters above.
- Single module; no sub-module. The optional output stage is a generate block inside the same module.

Test Plan:
- Reset then idle: assert reset for 2 cycles -> s_read_data=0; it stays 0 with s_read_req=0.
- Basic write/read, ADDR_WIDTH=5, DATA_WIDTH=16: write 0x1234 to addr 3, then read addr 3 -> s_read_data=0x1234 exactly 1 cycle after the read edge.
- Hold: read addr 3 (0x1234), then s_read_req=0 while addr changes to 7 -> s_read_data stays 0x1234.
- Read-during-write same address: addr 5 holds 0xAAAA; in one cycle write 0x5555 to addr 5 and read addr 5 -> output 0xAAAA; the next read of addr 5 returns 0x5555.
- Simultaneous independent ports: write addr 0 = 0x0001 while reading addr 31 (previously 0xFFFF) -> output 0xFFFF; then read addr 0 -> 0x0001.
- OUTPUT_REG=1: write 0x00BE to addr 2, read addr 2 -> data appears 2 cycles after the read edge. Reset asserted mid-pipeline -> output 0 the cycle after reset.

Source files
------------

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, shared clock.
// Latency: write 1 cycle; read 1 cycle (OUTPUT_REG=0) or 2 cycles (OUTPUT_REG=1).
// Backpressure: none; every read and write request is accepted in its own cycle.
module dual_port_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int OUTPUT_REG = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] s_write_addr,
   input  logic                  s_write_req,
   input  logic [DATA_WIDTH-1:0] s_write_data,
   input  logic [ADDR_WIDTH-1:0] s_read_addr,
   input  logic                  s_read_req,
   output logic [DATA_WIDTH-1:0] s_read_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Storage is deliberately left out of reset so it maps onto plain RAM cells.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] rd_d;

   // Write port: store the word at the addressed location; reset does not gate it.
   always_ff @(posedge clk) begin
      if (s_write_req) begin
         mem_q[s_write_addr] <= s_write_data;
      end
   end

   // First read stage next state: load on request, otherwise hold the last word.
   always_comb begin
      rd_d = rd_q;
      if (s_read_req) begin
         rd_d = mem_q[s_read_addr];
      end
   end

   // First read stage register; sampling mem_q before the write lands gives read-first.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   generate
      if (OUTPUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] out_q;

         // Second stage follows the first every cycle to relax output timing.
         always_ff @(posedge clk) begin
            if (reset) begin
               out_q <= '0;
            end else begin
               out_q <= rd_q;
            end
         end

         assign s_read_data = out_q;
      end else begin : g_no_out_reg
         assign s_read_data = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: one instance per output-register setting.
// Both instances share stimulus; expected data comes from a word-array model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_dual_port_ram;

   localparam int AW = 5;
   localparam int DW = 16;

   logic          clk;
   logic          reset;
   logic [AW-1:0] s_write_addr;
   logic          s_write_req;
   logic [DW-1:0] s_write_data;
   logic [AW-1:0] s_read_addr;
   logic          s_read_req;
   logic [DW-1:0] rd_lat1;
   logic [DW-1:0] rd_lat2;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: memory contents, latest word read since reset,
   // and the value that latest-read had one cycle earlier.
   logic [DW-1:0] mem_m [32];
   logic [DW-1:0] last_rd_m;
   logic [DW-1:0] last_rd_prev_m;

   dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) u_dut_l1 (
      .clk          (clk),
      .reset        (reset),
      .s_write_addr (s_write_addr),
      .s_write_req  (s_write_req),
      .s_write_data (s_write_data),
      .s_read_addr  (s_read_addr),
      .s_read_req   (s_read_req),
      .s_read_data  (rd_lat1)
   );

   dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) u_dut_l2 (
      .clk          (clk),
      .reset        (reset),
      .s_write_addr (s_write_addr),
      .s_write_req  (s_write_req),
      .s_write_data (s_write_data),
      .s_read_addr  (s_read_addr),
      .s_read_req   (s_read_req),
      .s_read_data  (rd_lat2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of stimulus, advance the model, and return 1 unit past the edge.
   task automatic cycle(input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
      reset        = rst;
      s_write_req  = we;
      s_write_addr = wa;
      s_write_data = wd;
      s_read_req   = re;
      s_read_addr  = ra;
      if (rst) begin
         last_rd_m      = '0;
         last_rd_prev_m = '0;
      end else begin
         last_rd_prev_m = last_rd_m;
         if (re) last_rd_m = mem_m[ra];
      end
      if (we) mem_m[wa] = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
      cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
      n_checks++;
      if (rd_lat1 !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_l1: got %h expected 0000", rd_lat1);
      end
      n_checks++;
      if (rd_lat2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_l2: got %h expected 0000", rd_lat2);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, '0, '0, 1'b0, AW'(i));
         n_checks++;
         if (rd_lat1 !== 16'h0000 || rd_lat2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h/%h expected 0000/0000", rd_lat1, rd_lat2);
         end
      end
   endtask

   task automatic test_basic;
      cycle(1'b0, 1'b1, 5'd3, 16'h1234, 1'b0, '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd3);
      n_checks++;
      if (rd_lat1 !== 16'h1234) begin
         n_fail++;
         $display("FAIL basic_read_l1: got %h expected 1234", rd_lat1);
      end
      n_checks++;
      if (rd_lat2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL basic_read_l2_early: got %h expected 0000", rd_lat2);
      end
   endtask

   task automatic test_hold;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, '0, '0, 1'b0, 5'd7);
         n_checks++;
         if (rd_lat1 !== 16'h1234) begin
            n_fail++;
            $display("FAIL hold_l1: got %h expected 1234", rd_lat1);
         end
      end
      n_checks++;
      if (rd_lat2 !== 16'h1234) begin
         n_fail++;
         $display("FAIL hold_l2: got %h expected 1234", rd_lat2);
      end
   endtask

   task automatic test_read_during_write;
      cycle(1'b0, 1'b1, 5'd5, 16'hAAAA, 1'b0, '0);
      cycle(1'b0, 1'b1, 5'd5, 16'h5555, 1'b1, 5'd5);
      n_checks++;
      if (rd_lat1 !== 16'hAAAA) begin
         n_fail++;
         $display("FAIL rdw_old_data: got %h expected aaaa", rd_lat1);
      end
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd5);
      n_checks++;
      if (rd_lat1 !== 16'h5555) begin
         n_fail++;
         $display("FAIL rdw_new_data: got %h expected 5555", rd_lat1);
      end
   endtask

   task automatic test_independent;
      cycle(1'b0, 1'b1, 5'd31, 16'hFFFF, 1'b0, '0);
      cycle(1'b0, 1'b1, 5'd0, 16'h0001, 1'b1, 5'd31);
      n_checks++;
      if (rd_lat1 !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL indep_read31: got %h expected ffff", rd_lat1);
      end
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd0);
      n_checks++;
      if (rd_lat1 !== 16'h0001) begin
         n_fail++;
         $display("FAIL indep_read0: got %h expected 0001", rd_lat1);
      end
   endtask

   task automatic test_output_reg;
      cycle(1'b0, 1'b1, 5'd2, 16'h00BE, 1'b0, '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd2);
      n_checks++;
      if (rd_lat2 !== 16'h0001) begin
         n_fail++;
         $display("FAIL outreg_one_cycle: got %h expected 0001", rd_lat2);
      end
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
      n_checks++;
      if (rd_lat2 !== 16'h00BE) begin
         n_fail++;
         $display("FAIL outreg_two_cycle: got %h expected 00be", rd_lat2);
      end
      // Put 0x1234 into the pipeline, then reset while it is still in flight.
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd3);
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd3);
      n_checks++;
      if (rd_lat2 !== 16'h0000 || rd_lat1 !== 16'h0000) begin
         n_fail++;
         $display("FAIL outreg_mid_reset: got %h/%h expected 0000/0000", rd_lat1, rd_lat2);
      end
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
      n_checks++;
      if (rd_lat2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL outreg_after_reset: got %h expected 0000", rd_lat2);
      end
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd2);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
      n_checks++;
      if (rd_lat2 !== 16'h00BE) begin
         n_fail++;
         $display("FAIL outreg_resume: got %h expected 00be", rd_lat2);
      end
   endtask

   task automatic test_random;
      // Give every location a known value so no read returns undefined data.
      for (int a = 0; a < 32; a++) begin
         cycle(1'b0, 1'b1, AW'(a), DW'($urandom), 1'b0, '0);
      end
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 31) == 0), 1'(($urandom)), AW'($urandom), DW'($urandom),
               1'(($urandom)), AW'($urandom));
         n_checks++;
         if (rd_lat1 !== last_rd_m) begin
            n_fail++;
            $display("FAIL random_l1 cycle %0d: got %h expected %h", i, rd_lat1, last_rd_m);
         end
         n_checks++;
         if (rd_lat2 !== last_rd_prev_m) begin
            n_fail++;
            $display("FAIL random_l2 cycle %0d: got %h expected %h", i, rd_lat2, last_rd_prev_m);
         end
      end
   endtask

   initial begin
      reset          = 1'b1;
      s_write_req    = 1'b0;
      s_write_addr   = '0;
      s_write_data   = '0;
      s_read_req     = 1'b0;
      s_read_addr    = '0;
      last_rd_m      = '0;
      last_rd_prev_m = '0;
      test_reset();
      test_basic();
      test_hold();
      test_read_during_write();
      test_independent();
      test_output_reg();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
